cpu_step_ctrl: RTL and testbench
================================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL name their ports clk and rst_n.
REQ-002 Parameter RUN_DIV, 8388608, clk cycles between cpu_ce pulses in RUN (~6 Hz at 50 MHz).
REQ-003 Parameter DEB_CYCLES, 1000000, consecutive stable cycles a key needs before it is accepted (20 ms at 50 MHz).
REQ-004 clk  in  1  system clock (board 50 MHz).
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 key_step_n  in  1  raw push-button, active-low, asynchronous to clk; requests a single step.
REQ-007 key_mode_n  in  1  raw push-button, active-low, asynchronous to clk; cycles the mode.
REQ-008 halt  in  1  level from the CPU; suppresses stepping.
REQ-009 cpu_ce  out  1  one-cycle clock-enable pulse to the CPU datapath (PC, regfile, FSM, BRAM).
REQ-010 run_mode  out  1  high only while in RUN.
REQ-011 step_cnt  out  16  count of cpu_ce pulses issued.
REQ-012 heartbeat  out  1  square wave that toggles on every divider terminal count.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer with reset value 1 (released).
REQ-014 Each debouncer SHALL hold a stable level (reset 1) and a counter (reset 0).
- Counter clears whenever the synchronized input equals the stable level.
- Otherwise the counter increments.
- When the counter reaches DEB_CYCLES-1, the stable level takes the input value and the counter clears.
REQ-015 A press event SHALL be a one-cycle pulse on a stable 1->0 transition; releases produce no event.
REQ-016 Press-event latency SHALL be 2 (sync) + DEB_CYCLES cycles after the raw key settles low.
REQ-017 The FSM SHALL have three states: STEP (reset state), RUN and HALTED.
REQ-018 STEP transitions:
- step press with halt=0 -> cpu_ce=1 in the following cycle.
- step press with halt=1 -> dropped.
- mode press -> RUN.
REQ-019 RUN transitions:
- cpu_ce pulses when the divider reaches RUN_DIV-1, provided halt=0.
- mode press -> STEP.
- halt=1 -> HALTED, with no cpu_ce in that cycle.
REQ-020 HALTED SHALL never assert cpu_ce; mode press -> STEP; step press is ignored.
REQ-021 If mode and step presses occur in the same cycle, mode SHALL win and the step press SHALL be dropped.
REQ-022 The divider SHALL count 0..RUN_DIV-1 and wrap in every state, and SHALL clear to 0 on entry to RUN, so the first RUN pulse comes RUN_DIV cycles after entry.
REQ-023 heartbeat SHALL toggle at every divider wrap.
REQ-024 step_cnt SHALL increment by 1 in the cycle after each cpu_ce and wrap from 0xFFFF to 0x0000.
REQ-025 cpu_ce SHALL never be high for two consecutive cycles.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On rst_n=0, all state SHALL clear immediately and asynchronously:
- state=STEP; cpu_ce=0; run_mode=0; step_cnt=0; heartbeat=0; divider=0.
- synchronizers=1; stable levels=1; debounce counters=0.
REQ-028 Reset asserted mid-RUN or mid-debounce SHALL abort the operation with no pending pulse.
REQ-029 After reset release, the first press SHALL require the full debounce interval.

Structure
REQ-030 Package cpu_ctrl_pkg SHALL hold the state enum {STEP, RUN, HALTED} and the default RUN_DIV and DEB_CYCLES constants.
REQ-031 Debouncing SHALL be sub-module key_debounce (synchronizer, debounce counter, press pulse), parameterized by DEB_CYCLES and instantiated twice.

Verification (RUN_DIV=8, DEB_CYCLES=4)
REQ-032 Bounce test: reset, then key_step_n bounces 0,1,0,1 over 4 cycles and is then held low 10 cycles -> exactly one cpu_ce, 7 cycles after the final falling edge; step_cnt=1.
REQ-033 Run test: mode press -> run_mode=1, then cpu_ce at entry+8, +16 and +24; heartbeat toggles at the same points; a second mode press -> run_mode=0 and pulses stop.
REQ-034 Halt test: in RUN, raise halt at divider=5 -> no further cpu_ce, state HALTED, run_mode=0; step press ignored; mode press -> STEP; step press with halt=0 -> one cpu_ce.
REQ-035 Simultaneous press: in STEP, mode and step press in the same cycle -> RUN entered, no cpu_ce for 8 cycles.
REQ-036 Wrap and reset test:
- RUN with RUN_DIV=2 for 65536 pulses -> step_cnt=0x0000.
- Then assert rst_n=0 mid-count -> all outputs 0 within the same cycle; the next step press needs the full 6-cycle latency.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and defaults for the single-step / free-run CPU clock-enable controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    STEP   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Board defaults at 50 MHz: ~6 Hz run rate, 20 ms debounce.
  localparam int unsigned RUN_DIV_DEFAULT    = 8388608;
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;
  localparam int unsigned STEP_CNT_W         = 16;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// CPU-facing signals of the step controller: halt in, clock enable and status out.
interface cpu_step_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic                  halt;
  logic                  cpu_ce;
  logic                  run_mode;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic                  heartbeat;

  modport master (
    input  halt,
    output cpu_ce, run_mode, step_cnt, heartbeat
  );

  modport slave (
    output halt,
    input  cpu_ce, run_mode, step_cnt, heartbeat
  );
endinterface

// File: rtl/cpu_step_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse.
module key_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clk domain; released (1) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the stable one for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        // Only a 1->0 acceptance is a press; stable is still the old level here.
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: single-step on key, free-run from a divider, halt from the CPU.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV    = RUN_DIV_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_step_n,
  input  logic                   key_mode_n,
  cpu_step_ctrl_if.master        cpu
);

  localparam int unsigned DIV_W = cnt_width(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  ctrl_state_t           state_q;
  ctrl_state_t           state_d;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      div_d;
  logic                  div_wrap;
  logic                  ce_d;
  logic                  ce_q;
  logic                  run_q;
  logic                  hb_q;
  logic [STEP_CNT_W-1:0] cnt_q;
  logic                  step_press;
  logic                  mode_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_step_n),
    .press (step_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  assign div_wrap = (div_q == DIV_LAST);

  // Next state and clock-enable request; a mode press always beats a step press.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    unique case (state_q)
      STEP: begin
        if (mode_press)                   state_d = RUN;
        else if (step_press && !cpu.halt) ce_d    = 1'b1;
      end
      RUN: begin
        if (mode_press)    state_d = STEP;
        else if (cpu.halt) state_d = HALTED;
        else if (div_wrap) ce_d    = 1'b1;
      end
      HALTED: begin
        if (mode_press) state_d = STEP;
      end
      default: state_d = STEP;
    endcase
    // Keeps pulses isolated even for a degenerate RUN_DIV of 1.
    ce_d = ce_d & ~ce_q;
  end

  // Free-running divider, restarted on RUN entry so the first pulse is a full period away.
  always_comb begin
    div_d = div_q + 1'b1;
    if ((state_q != RUN) && (state_d == RUN)) div_d = '0;
    else if (div_wrap)                        div_d = '0;
  end

  // State and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STEP;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // Registered outputs: enable pulse, mode flag, heartbeat and pulse counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q  <= 1'b0;
      run_q <= 1'b0;
      hb_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ce_q  <= ce_d;
      run_q <= (state_d == RUN);
      if (div_wrap) hb_q  <= ~hb_q;
      if (ce_q)     cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cpu.cpu_ce    = ce_q;
  assign cpu.run_mode  = run_q;
  assign cpu.heartbeat = hb_q;
  assign cpu.step_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: pulse timing scoreboard, modes, halt, wrap and reset.
module tb_cpu_step_ctrl;

  localparam int RUN_DIV_A = 8;

  logic clk = 1'b0;
  logic rst_n, rst_b_n;
  logic key_step_a, key_mode_a, key_step_b, key_mode_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int a_pulses = 0;
  int b_pulses = 0;
  logic hb_prev_a = 1'b0;
  logic ce_prev_a = 1'b0;

  cpu_step_ctrl_if cif_a ();
  cpu_step_ctrl_if cif_b ();

  cpu_step_ctrl #(.RUN_DIV(RUN_DIV_A), .DEB_CYCLES(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_step_n (key_step_a),
    .key_mode_n (key_mode_a),
    .cpu        (cif_a)
  );

  cpu_step_ctrl #(.RUN_DIV(2), .DEB_CYCLES(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_b_n),
    .key_step_n (key_step_b),
    .key_mode_n (key_mode_b),
    .cpu        (cif_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic press_a(input logic s, input logic m);
    if (s) key_step_a = 1'b0;
    if (m) key_mode_a = 1'b0;
    repeat (8) tick();
    key_step_a = 1'b1;
    key_mode_a = 1'b1;
    repeat (8) tick();
  endtask

  // Expected RUN pulses for a stay in RUN from entry edge to exit edge.
  task automatic push_run(input int entry, input int exit_c);
    for (int p = entry + RUN_DIV_A; p < exit_c; p += RUN_DIV_A) exp_q.push_back(p);
  endtask

  // Scoreboard pop for DUT A: each cpu_ce must land on the predicted cycle.
  always @(negedge clk) begin
    int want_cyc;
    if (rst_n && cif_a.cpu_ce) begin
      want_cyc = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      chk("ce_cycle", cyc, want_cyc);
      chk("ce_step_cnt", {16'd0, cif_a.step_cnt}, a_pulses);
      chk("ce_isolated", {31'd0, ce_prev_a}, 0);
      if (cif_a.run_mode) chk("hb_toggle", {31'd0, cif_a.heartbeat}, {31'd0, !hb_prev_a});
      a_pulses++;
    end
    hb_prev_a = cif_a.heartbeat;
    ce_prev_a = cif_a.cpu_ce;
  end

  always @(negedge clk) if (cif_b.cpu_ce) b_pulses++;

  initial begin
    int k;
    int entry;
    int guard;
    rst_n = 1'b0; rst_b_n = 1'b0;
    key_step_a = 1'b1; key_mode_a = 1'b1;
    key_step_b = 1'b1; key_mode_b = 1'b1;
    cif_a.halt = 1'b0; cif_b.halt = 1'b0;
    #1;
    chk("reset_outputs", {12'd0, cif_a.cpu_ce, cif_a.run_mode, cif_a.heartbeat, cif_a.step_cnt}, 0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1; rst_b_n = 1'b1;
    tick();
    chk("post_reset_cnt", {16'd0, cif_a.step_cnt}, 0);
    chk("post_reset_mode", {31'd0, cif_a.run_mode}, 0);

    // Bounce: 0,1,0,1 then held low 10 cycles; one pulse 7 cycles after final fall.
    k = cyc;
    exp_q.push_back(k + 4 + 7);
    key_step_a = 1'b0; tick();
    key_step_a = 1'b1; tick();
    key_step_a = 1'b0; tick();
    key_step_a = 1'b1; tick();
    key_step_a = 1'b0;
    repeat (10) tick();
    key_step_a = 1'b1;
    repeat (10) tick();
    chk("bounce_pending", exp_q.size(), 0);
    chk("bounce_pulses", a_pulses, 1);
    chk("bounce_step_cnt", {16'd0, cif_a.step_cnt}, 1);

    // Step press while halt=1 in STEP is dropped.
    cif_a.halt = 1'b1;
    press_a(1'b1, 1'b0);
    cif_a.halt = 1'b0;
    chk("halted_step_cnt", {16'd0, cif_a.step_cnt}, 1);

    // Run: pulses at entry+8/16/24, second mode press at k+32 leaves RUN at k+39.
    k = cyc;
    entry = k + 7;
    push_run(entry, k + 32 + 7);
    press_a(1'b0, 1'b1);
    chk("run_mode_on", {31'd0, cif_a.run_mode}, 1);
    wait_until(k + 32);
    press_a(1'b0, 1'b1);
    repeat (20) tick();
    chk("run_mode_off", {31'd0, cif_a.run_mode}, 0);
    chk("run_pending", exp_q.size(), 0);
    chk("run_pulses", a_pulses, 4);

    // Halt at divider 5 (five cycles after RUN entry): no pulses, HALTED.
    k = cyc;
    key_mode_a = 1'b0;
    wait_until(k + 8);
    key_mode_a = 1'b1;
    wait_until(k + 12);
    cif_a.halt = 1'b1;
    wait_until(k + 14);
    chk("halted_run_mode", {31'd0, cif_a.run_mode}, 0);
    wait_until(k + 24);
    cif_a.halt = 1'b0;
    press_a(1'b1, 1'b0);
    chk("halted_ignores_step", a_pulses, 4);
    press_a(1'b0, 1'b1);
    chk("halted_to_step", {31'd0, cif_a.run_mode}, 0);
    k = cyc;
    exp_q.push_back(k + 7);
    press_a(1'b1, 1'b0);
    chk("halt_pending", exp_q.size(), 0);
    chk("halt_step_cnt", {16'd0, cif_a.step_cnt}, 5);

    // Simultaneous press: mode wins, first pulse is the RUN pulse at entry+8.
    k = cyc;
    entry = k + 7;
    push_run(entry, k + 16 + 7);
    press_a(1'b1, 1'b1);
    chk("simul_run_mode", {31'd0, cif_a.run_mode}, 1);
    press_a(1'b0, 1'b1);
    repeat (4) tick();
    chk("simul_pending", exp_q.size(), 0);
    chk("simul_pulses", a_pulses, 6);
    chk("simul_exit", {31'd0, cif_a.run_mode}, 0);

    // Wrap on DUT B (RUN_DIV=2): 65536 RUN pulses bring step_cnt back to 0.
    key_mode_b = 1'b0;
    repeat (8) tick();
    key_mode_b = 1'b1;
    b_pulses = 0;
    guard = 0;
    while (b_pulses < 65536 && guard < 140000) begin
      tick();
      guard++;
    end
    chk("wrap_pulses", b_pulses, 65536);
    chk("wrap_step_cnt", {16'd0, cif_b.step_cnt}, 0);

    // Asynchronous reset in the middle of a pulse.
    guard = 0;
    while (cif_b.cpu_ce !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    chk("pre_reset_ce", {31'd0, cif_b.cpu_ce}, 1);
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("async_reset_outputs", {12'd0, cif_b.cpu_ce, cif_b.run_mode, cif_b.heartbeat, cif_b.step_cnt}, 0);
    tick();
    @(negedge clk);
    rst_b_n = 1'b1;
    tick();
    k = cyc;
    key_step_b = 1'b0;
    guard = 0;
    while (cif_b.cpu_ce !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("post_reset_latency", cyc - k, 7);
    tick();
    chk("post_reset_step_cnt", {16'd0, cif_b.step_cnt}, 1);
    key_step_b = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
